// File: rtl/dfa_feeder_pkg.sv
// dfa_feeder_pkg: shared widths, FSM encodings and constants for the DFA flow feeder.
package dfa_feeder_pkg;
   localparam int STATE_W   = 11;
   localparam int NUM_FLOWS = 16;
   localparam int FLOW_W    = 4;
   localparam int CNT_W     = 16;
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_SAVE   = 3'd3;
   localparam logic [2:0] S_REPORT = 3'd4;
   localparam logic [CNT_W-1:0] CNT_ALL_ONES = '1;
endpackage

// File: rtl/dfa_flow_feeder_if.sv
// dfa_flow_feeder_if: packet input, matcher char/state and report channels of the flow feeder.
interface dfa_flow_feeder_if #(
   parameter int STATE_W = dfa_feeder_pkg::STATE_W,
   parameter int FLOW_W  = dfa_feeder_pkg::FLOW_W,
   parameter int CNT_W   = dfa_feeder_pkg::CNT_W
);
   logic [7:0]         pkt_data;
   logic               pkt_vld;
   logic               pkt_sop;
   logic               pkt_eop;
   logic [FLOW_W-1:0]  pkt_flow;
   logic               pkt_rdy;
   logic [7:0]         char_out;
   logic               char_out_vld;
   logic [STATE_W-1:0] state_load;
   logic               state_load_vld;
   logic [STATE_W-1:0] eng_state;
   logic               eng_accept;
   logic               rpt_vld;
   logic               rpt_rdy;
   logic [FLOW_W-1:0]  rpt_flow;
   logic [CNT_W-1:0]   rpt_match_cnt;
   logic [CNT_W-1:0]   rpt_first_off;
   modport master (
      input  pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_flow, eng_state, eng_accept, rpt_rdy,
      output pkt_rdy, char_out, char_out_vld, state_load, state_load_vld,
             rpt_vld, rpt_flow, rpt_match_cnt, rpt_first_off
   );
   modport slave (
      output pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_flow, eng_state, eng_accept, rpt_rdy,
      input  pkt_rdy, char_out, char_out_vld, state_load, state_load_vld,
             rpt_vld, rpt_flow, rpt_match_cnt, rpt_first_off
   );
endinterface

// File: rtl/dfa_flow_feeder_ctx_table.sv
// dfa_ctx_table: per-flow saved DFA state; async read, one write port, clear beats write.
module dfa_ctx_table #(
   parameter int NUM_FLOWS = dfa_feeder_pkg::NUM_FLOWS,
   parameter int STATE_W   = dfa_feeder_pkg::STATE_W,
   parameter int FLOW_W    = dfa_feeder_pkg::FLOW_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FLOW_W-1:0]  rd_addr,
   output logic [STATE_W-1:0] rd_data,
   input  logic               wr_en,
   input  logic [FLOW_W-1:0]  wr_addr,
   input  logic [STATE_W-1:0] wr_data,
   input  logic               clr_en,
   input  logic [FLOW_W-1:0]  clr_addr
);
   logic [STATE_W-1:0] mem [NUM_FLOWS];
   assign rd_data = mem[rd_addr];
   always_ff @(posedge clk or posedge rst)
      if (rst)
         for (int i = 0; i < NUM_FLOWS; i++) mem[i] <= '0;
      else
         for (int i = 0; i < NUM_FLOWS; i++)
            if (clr_en && clr_addr == FLOW_W'(i)) mem[i] <= '0;
            else if (wr_en && wr_addr == FLOW_W'(i)) mem[i] <= wr_data;
endmodule

// File: rtl/dfa_flow_feeder.sv
// dfa_flow_feeder: restores per-flow DFA state, streams packet bytes to the matcher, saves state, reports matches.
// Optional statistics counters are built when DFA_FEEDER_STATS_EN is defined.
module dfa_flow_feeder #(
   parameter int STATE_W   = dfa_feeder_pkg::STATE_W,
   parameter int NUM_FLOWS = dfa_feeder_pkg::NUM_FLOWS,
   parameter int FLOW_W    = dfa_feeder_pkg::FLOW_W,
   parameter int CNT_W     = dfa_feeder_pkg::CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   dfa_flow_feeder_if.master   bus,
   input  logic                ctx_clr,
   input  logic [FLOW_W-1:0]   ctx_clr_flow,
   output logic                err_sticky,
   output logic [31:0]         stat_pkts,
   output logic [31:0]         stat_bytes,
   output logic [31:0]         stat_matches
);
   import dfa_feeder_pkg::*;
   logic [2:0]         st;
   logic [FLOW_W-1:0]  flow;
   logic [CNT_W-1:0]   match_cnt, offset, first_off;
   logic [STATE_W-1:0] ctx_rd;
   logic               beat;
   assign beat               = st == S_STREAM && bus.pkt_vld;
   // rst gate keeps the IDLE drop-path ready low while reset is held
   assign bus.pkt_rdy        = !rst && (st == S_STREAM || (st == S_IDLE && bus.pkt_vld && !bus.pkt_sop));
   assign bus.char_out       = st == S_STREAM ? bus.pkt_data : '0;
   assign bus.char_out_vld   = beat;
   assign bus.state_load     = st == S_LOAD ? ctx_rd : '0;
   assign bus.state_load_vld = st == S_LOAD;
   assign bus.rpt_vld        = st == S_REPORT;
   assign bus.rpt_flow       = flow;
   assign bus.rpt_match_cnt  = match_cnt;
   assign bus.rpt_first_off  = first_off;
   dfa_ctx_table #(.NUM_FLOWS(NUM_FLOWS), .STATE_W(STATE_W), .FLOW_W(FLOW_W)) u_ctx (
      .clk(clk), .rst(rst), .rd_addr(flow), .rd_data(ctx_rd),
      .wr_en(st == S_SAVE), .wr_addr(flow), .wr_data(bus.eng_state),
      .clr_en(ctx_clr), .clr_addr(ctx_clr_flow)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st         <= S_IDLE;
         flow       <= '0;
         match_cnt  <= '0;
         offset     <= '0;
         first_off  <= '0;
         err_sticky <= 1'b0;
      end else
         case (st)
            S_IDLE:
               if (bus.pkt_vld) begin
                  if (bus.pkt_sop) begin
                     flow <= bus.pkt_flow;
                     st   <= S_LOAD;
                  end else err_sticky <= 1'b1;
               end
            S_LOAD: begin
               match_cnt <= '0;
               offset    <= '0;
               first_off <= '1;
               st        <= S_STREAM;
            end
            S_STREAM:
               if (bus.pkt_vld) begin
                  if (bus.eng_accept) begin
                     if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
                     if (first_off == '1) first_off <= offset;
                  end
                  if (offset != '1) offset <= offset + CNT_W'(1);
                  // offset leaves zero after the first beat and never returns, so it marks a mid-packet SOP
                  if (bus.pkt_sop && offset != '0) err_sticky <= 1'b1;
                  if (bus.pkt_eop) st <= S_SAVE;
               end
            S_SAVE:   st <= S_REPORT;
            S_REPORT: if (bus.rpt_rdy) st <= S_IDLE;
            default:  st <= S_IDLE;
         endcase
`ifdef DFA_FEEDER_STATS_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         stat_pkts    <= '0;
         stat_bytes   <= '0;
         stat_matches <= '0;
      end else begin
         if (st == S_REPORT && bus.rpt_rdy) stat_pkts <= stat_pkts + 32'd1;
         if (beat) stat_bytes <= stat_bytes + 32'd1;
         if (beat && bus.eng_accept) stat_matches <= stat_matches + 32'd1;
      end
`else
   assign stat_pkts    = '0;
   assign stat_bytes   = '0;
   assign stat_matches = '0;
`endif
endmodule
